spi_master_multi: RTL and testbench
===================================

# spi_master_multi

Parametrised SPI master: the next generation of the team's fixed 8-bit, single-slave, mode-0 SPI master. It adds configurable word width, clock divider, bit order, runtime CPOL/CPHA selection and multiple chip selects. It sits between a register/command interface (single-pulse `start`) and off-chip SPI slaves, and runs full-duplex word transfers in one `clk` domain.

## Interface
- `DATA_W`, 8: bits per transfer, ≥2.
- `CLK_DIV`, 4: `clk` cycles per SCLK half-period, ≥1.
- `NUM_CS`, 2: number of chip-select outputs, ≥1.
- `CS_W`, `$clog2(NUM_CS)` (min 1): width of `cs_sel`.
- `LSB_FIRST`, 0: 0 = MSB shifted first, 1 = LSB first (both directions).

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a transfer; accepted only when `busy`=0.
- `cpol` in 1: SCLK idle level; latched at accept.
- `cpha` in 1: 0 = sample on leading edge, 1 = sample on trailing edge; latched at accept.
- `cs_sel` in CS_W: slave index; latched at accept.
- `data_in` in DATA_W: transmit word; latched at accept.
- `data_out` out DATA_W: received word; updated only in the `done` cycle.
- `done` out 1: one-cycle pulse at transfer end.
- `busy` out 1: high from the cycle after accept through the last HOLD cycle.
- `sclk` out 1: SPI clock.
- `mosi` out 1: serial data out.
- `miso` in 1: serial data in, treated as synchronous to `clk`.
- `cs_n` out NUM_CS: active-low chip selects, one-hot-low while active.

## Operation
- FSM states: IDLE → SETUP → XFER → HOLD → IDLE.
- IDLE
  - `sclk` = `cpol` input, registered each cycle.
  - All `cs_n` high; `mosi`=0.
  - `start`=1 latches `cpol`/`cpha`/`cs_sel`/`data_in` into the shift register and moves to SETUP.
- SETUP, CLK_DIV cycles
  - `cs_n[cs_sel]`=0; `sclk` = latched cpol.
  - `mosi` = first bit: `data_in[DATA_W-1]`, or `[0]` if LSB_FIRST.
- XFER, 2·DATA_W half-periods k=0..2·DATA_W-1, each CLK_DIV cycles
  - `sclk` = cpol XOR (k even).
  - Leading edges open even k; trailing edges open odd k.
- Bit shifting
  - CPHA=0: `mosi` advances to the next bit at the start of odd half-periods k=1,3,…,2·DATA_W-3. `miso` is captured on the `clk` edge ending each even half-period.
  - CPHA=1: `mosi` advances at the start of even half-periods k=2,4,…,2·DATA_W-2. `miso` is captured on the `clk` edge ending each odd half-period.
  - Receive bits fill in the configured bit order.
- HOLD, CLK_DIV cycles: `sclk` at cpol; `cs_n` still asserted; `mosi` holds the last bit.
- Exit cycle, next IDLE cycle:
  - all `cs_n` high, `done`=1, `busy`=0;
  - `data_out` = received word;
  - `mosi`=0.
- `start` while `busy`=1 is ignored; no queueing.
- `start` in the `done` cycle is accepted, giving back-to-back transfers.
- `cs_sel` ≥ NUM_CS: no `cs_n` asserts, but the transfer runs fully and `done` pulses.
- Input changes during a transfer have no effect.
- Exactly DATA_W leading and DATA_W trailing SCLK edges per transfer.

## Timing
- Reset values, asserted the cycle after `rst`=1 is sampled regardless of state:
  - state IDLE; `sclk`=0, `mosi`=0;
  - `cs_n` all 1;
  - `busy`=0, `done`=0, `data_out`=0.
- Accept at edge T: `busy` and `cs_n` assert at T+1.
- First leading SCLK edge at T+1+CLK_DIV.
- `done` at T+1+CLK_DIV·(2·DATA_W+2). For DATA_W=8, CLK_DIV=4 this is T+73.
- CS-to-first-edge and last-edge-to-CS-release are each ≥ CLK_DIV cycles.
- Reset mid-transfer aborts immediately: no `done`, `data_out` cleared, `cs_n` released next cycle.

## Test plan
- Mode 0 (cpol=0, cpha=0), `cs_sel`=0, `data_in`=0xA5, `miso` looped from `mosi`:
  - `data_out`=0xA5;
  - `done` at T+73;
  - 8 rising `sclk` edges; only `cs_n[0]` low.
- Mode 3 (cpol=1, cpha=1), `cs_sel`=1, slave model drives 0x3C shifting on falling edges and sampling on rising:
  - `data_out`=0x3C; slave receives `data_in`=0xC3;
  - `sclk` idles high; only `cs_n[1]` low.
- LSB_FIRST=1, DATA_W=16, CLK_DIV=1, loopback 0x1234:
  - `mosi` bit sequence starts with 0,0,1,0;
  - `data_out`=0x1234; `done` at T+35.
- `start` pulsed again mid-transfer, then again in the `done` cycle:
  - mid-transfer pulse ignored;
  - second transfer begins with `busy`=1 and `cs_n` low the next cycle.
- `rst`=1 during XFER half-period 5:
  - next cycle `cs_n` all high, `busy`=0, `sclk`=0;
  - no `done` pulse; a subsequent transfer completes normally.
- `cs_sel`=3 with NUM_CS=2: all `cs_n` stay high; 8 SCLK cycles still occur; `done` pulses at T+73.

Source files
------------

// File: rtl/spi_master_multi.sv
// Parametrised full-duplex SPI master with runtime CPOL/CPHA, selectable bit order
// and NUM_CS one-hot-low chip selects. Every SPI-facing output is registered.
module spi_master_multi #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter int NUM_CS    = 2,
    parameter int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
    parameter int LSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HALF_W = $clog2(2 * DATA_W);
    localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(CLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST   = HALF_W'(2 * DATA_W - 1);
    localparam logic [HALF_W-1:0] HALF_PENULT = HALF_W'(2 * DATA_W - 2);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_t;

    state_t              r_state, w_state_next;
    logic [DIV_W-1:0]    r_div, w_div_next;
    logic [HALF_W-1:0]   r_half, w_half_next;
    logic [DATA_W-1:0]   r_tx, w_tx_next;
    logic [DATA_W-1:0]   r_rx, w_rx_next;
    logic                r_cpol, w_cpol_next;
    logic                r_cpha, w_cpha_next;
    logic [CS_W-1:0]     r_cs, w_cs_next;
    logic                r_sclk, w_sclk_next;
    logic                r_mosi, w_mosi_next;
    logic [NUM_CS-1:0]   r_cs_n, w_cs_n_next;
    logic                r_busy, r_done, w_done_next;
    logic [DATA_W-1:0]   r_data_out, w_data_out_next;
    logic                w_half_end, w_capture, w_shift;

    // Capture closes the sampling half-period; shifting opens the next launch half-period
    // but never past the last bit, so mosi holds it through HOLD.
    always_comb begin
        w_state_next    = r_state;
        w_div_next      = r_div;
        w_half_next     = r_half;
        w_tx_next       = r_tx;
        w_rx_next       = r_rx;
        w_cpol_next     = r_cpol;
        w_cpha_next     = r_cpha;
        w_cs_next       = r_cs;
        w_done_next     = 1'b0;
        w_data_out_next = r_data_out;
        w_half_end      = (r_div == DIV_LAST);
        w_capture       = (r_half[0] == r_cpha);
        w_shift         = r_cpha ? (r_half[0] && (r_half != HALF_LAST))
                                 : (!r_half[0] && (r_half != HALF_PENULT));
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_SETUP;
                    w_div_next   = '0;
                    w_half_next  = '0;
                    w_tx_next    = data_in;
                    w_rx_next    = '0;
                    w_cpol_next  = cpol;
                    w_cpha_next  = cpha;
                    w_cs_next    = cs_sel;
                end
            end
            S_SETUP: begin
                if (w_half_end) begin
                    w_state_next = S_XFER;
                    w_div_next   = '0;
                end else begin
                    w_div_next = r_div + 1'b1;
                end
            end
            S_XFER: begin
                if (w_half_end) begin
                    w_div_next = '0;
                    if (w_capture) begin
                        w_rx_next = (LSB_FIRST != 0) ? {miso, r_rx[DATA_W-1:1]}
                                                     : {r_rx[DATA_W-2:0], miso};
                    end
                    if (w_shift) begin
                        w_tx_next = (LSB_FIRST != 0) ? {1'b0, r_tx[DATA_W-1:1]}
                                                     : {r_tx[DATA_W-2:0], 1'b0};
                    end
                    if (r_half == HALF_LAST) begin
                        w_state_next = S_HOLD;
                    end else begin
                        w_half_next = r_half + 1'b1;
                    end
                end else begin
                    w_div_next = r_div + 1'b1;
                end
            end
            S_HOLD: begin
                if (w_half_end) begin
                    w_state_next    = S_IDLE;
                    w_div_next      = '0;
                    w_done_next     = 1'b1;
                    w_data_out_next = r_rx;
                end else begin
                    w_div_next = r_div + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Pin values are derived from the next state so they change on the same edge as the FSM.
    always_comb begin
        w_sclk_next = cpol;
        w_mosi_next = 1'b0;
        case (w_state_next)
            S_SETUP, S_HOLD: w_sclk_next = w_cpol_next;
            S_XFER:          w_sclk_next = w_cpol_next ^ ~w_half_next[0];
            default:         w_sclk_next = cpol;
        endcase
        if (w_state_next != S_IDLE) begin
            w_mosi_next = (LSB_FIRST != 0) ? w_tx_next[0] : w_tx_next[DATA_W-1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CS; gi++) begin : g_cs
            assign w_cs_n_next[gi] = !((w_state_next != S_IDLE) && (int'(w_cs_next) == gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_half     <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_cs       <= '0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= '1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_state    <= w_state_next;
            r_div      <= w_div_next;
            r_half     <= w_half_next;
            r_tx       <= w_tx_next;
            r_rx       <= w_rx_next;
            r_cpol     <= w_cpol_next;
            r_cpha     <= w_cpha_next;
            r_cs       <= w_cs_next;
            r_sclk     <= w_sclk_next;
            r_mosi     <= w_mosi_next;
            r_cs_n     <= w_cs_n_next;
            r_busy     <= (w_state_next != S_IDLE);
            r_done     <= w_done_next;
            r_data_out <= w_data_out_next;
        end
    end

    assign data_out = r_data_out;
    assign done     = r_done;
    assign busy     = r_busy;
    assign sclk     = r_sclk;
    assign mosi     = r_mosi;
    assign cs_n     = r_cs_n;

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: an 8-bit/CLK_DIV=4 instance with a 2-bit cs_sel
// and a 16-bit LSB-first CLK_DIV=1 instance, both checked against hand-computed values.
module tb_spi_master_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, cpol, cpha;
    logic start0, done0, busy0, sclk0, mosi0, miso0;
    logic [1:0] cs_sel0, cs_n0;
    logic [7:0] din0, dout0;
    logic start1, done1, busy1, sclk1, mosi1, miso1;
    logic [0:0] cs_sel1;
    logic [1:0] cs_n1;
    logic [15:0] din1, dout1;

    logic loop0;
    logic s_prev, s_out;
    logic [7:0] s_tx;
    logic [7:0] s_rx = 8'h00;

    int n_vec = 0;
    int n_bad = 0;

    spi_master_multi #(.DATA_W(8), .CLK_DIV(4), .NUM_CS(2), .CS_W(2), .LSB_FIRST(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .cpol(cpol), .cpha(cpha), .cs_sel(cs_sel0),
        .data_in(din0), .data_out(dout0), .done(done0), .busy(busy0), .sclk(sclk0),
        .mosi(mosi0), .miso(miso0), .cs_n(cs_n0));

    spi_master_multi #(.DATA_W(16), .CLK_DIV(1), .NUM_CS(2), .LSB_FIRST(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .cpol(cpol), .cpha(cpha), .cs_sel(cs_sel1),
        .data_in(din1), .data_out(dout1), .done(done1), .busy(busy1), .sclk(sclk1),
        .mosi(mosi1), .miso(miso1), .cs_n(cs_n1));

    assign miso0 = loop0 ? mosi0 : s_out;
    assign miso1 = mosi1;

    // Mode-3 slave on cs_n[1]: drives 0x3C (shift on falling), samples mosi on rising.
    always @(posedge clk) begin
        s_prev <= sclk0;
        if (cs_n0[1]) begin
            s_tx  <= 8'h3C;
            s_out <= 1'b0;
        end else begin
            if (s_prev && !sclk0) begin
                s_out <= s_tx[7];
                s_tx  <= {s_tx[6:0], 1'b0};
            end
            if (!s_prev && sclk0) s_rx <= {s_rx[6:0], mosi0};
        end
    end

    // Starts one transfer on DUT d and watches it until done (bounded); cyc=1 is the cycle after accept.
    task automatic run_xfer(input int d, input logic [1:0] cs, input logic [15:0] din,
                            output int cyc, output int rises, output int falls,
                            output logic [1:0] cs_seen, output logic [15:0] mbits,
                            output logic [15:0] rdata, output logic got_done);
        logic prev, cur, dn;
        rises = 0; falls = 0; cs_seen = 2'b00; mbits = 16'h0; rdata = 16'h0; got_done = 1'b0;
        @(negedge clk);
        if (d == 0) begin cs_sel0 = cs; din0 = din[7:0]; start0 = 1'b1; end
        else        begin cs_sel1 = cs[0]; din1 = din;  start1 = 1'b1; end
        prev = (d == 0) ? sclk0 : sclk1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        cyc = 1;
        while (cyc < 300) begin
            cur = (d == 0) ? sclk0 : sclk1;
            if (cur && !prev) begin
                if (rises < 16) mbits[rises] = (d == 0) ? mosi0 : mosi1;
                rises++;
            end
            if (!cur && prev) falls++;
            prev = cur;
            cs_seen = cs_seen | ((d == 0) ? ~cs_n0 : ~cs_n1);
            dn = (d == 0) ? done0 : done1;
            if (dn) begin
                got_done = 1'b1;
                rdata = (d == 0) ? {8'h00, dout0} : dout1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        $display("xfer dut%0d cs=%0d din=%h dout=%h cycles=%0d rises=%0d falls=%0d done=%0b",
                 d, cs, din, rdata, cyc, rises, falls, got_done);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (cs_n0 !== 2'b11) begin n_bad++; $display("FAIL reset_cs_n0: got %b expected 11", cs_n0); end
        n_vec++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy0: got %b expected 0", busy0); end
        n_vec++; if (done0 !== 1'b0) begin n_bad++; $display("FAIL reset_done0: got %b expected 0", done0); end
        n_vec++; if (sclk0 !== 1'b0) begin n_bad++; $display("FAIL reset_sclk0: got %b expected 0", sclk0); end
        n_vec++; if (mosi0 !== 1'b0) begin n_bad++; $display("FAIL reset_mosi0: got %b expected 0", mosi0); end
        n_vec++; if (dout0 !== 8'h00) begin n_bad++; $display("FAIL reset_dout0: got %h expected 00", dout0); end
        n_vec++; if (cs_n1 !== 2'b11) begin n_bad++; $display("FAIL reset_cs_n1: got %b expected 11", cs_n1); end
        n_vec++; if (dout1 !== 16'h0) begin n_bad++; $display("FAIL reset_dout1: got %h expected 0000", dout1); end
        rst = 1'b0;
        $display("reset applied");
    endtask

    task automatic test_mode0_loopback();
        int cyc, ri, fa; logic [1:0] cs; logic [15:0] mb, rd; logic gd;
        loop0 = 1'b1; cpol = 1'b0; cpha = 1'b0;
        run_xfer(0, 2'd0, 16'h00A5, cyc, ri, fa, cs, mb, rd, gd);
        n_vec++; if (gd !== 1'b1) begin n_bad++; $display("FAIL m0_done_seen: got %b expected 1", gd); end
        n_vec++; if (cyc != 73) begin n_bad++; $display("FAIL m0_done_time: got %0d expected 73", cyc); end
        n_vec++; if (rd !== 16'h00A5) begin n_bad++; $display("FAIL m0_data: got %h expected 00a5", rd); end
        n_vec++; if (ri != 8) begin n_bad++; $display("FAIL m0_rises: got %0d expected 8", ri); end
        n_vec++; if (fa != 8) begin n_bad++; $display("FAIL m0_falls: got %0d expected 8", fa); end
        n_vec++; if (cs !== 2'b01) begin n_bad++; $display("FAIL m0_cs_seen: got %b expected 01", cs); end
        n_vec++; if (mb[7:0] !== 8'b1010_0101) begin n_bad++; $display("FAIL m0_mosi_bits: got %b expected 10100101", mb[7:0]); end
        @(posedge clk); #1;
        n_vec++; if (done0 !== 1'b0) begin n_bad++; $display("FAIL m0_done_width: got %b expected 0", done0); end
        n_vec++; if (mosi0 !== 1'b0) begin n_bad++; $display("FAIL m0_idle_mosi: got %b expected 0", mosi0); end
    endtask

    task automatic test_mode3_slave();
        int cyc, ri, fa; logic [1:0] cs; logic [15:0] mb, rd; logic gd;
        loop0 = 1'b0; cpol = 1'b1; cpha = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (sclk0 !== 1'b1) begin n_bad++; $display("FAIL m3_idle_sclk: got %b expected 1", sclk0); end
        run_xfer(0, 2'd1, 16'h00C3, cyc, ri, fa, cs, mb, rd, gd);
        n_vec++; if (rd !== 16'h003C) begin n_bad++; $display("FAIL m3_data: got %h expected 003c", rd); end
        n_vec++; if (s_rx !== 8'hC3) begin n_bad++; $display("FAIL m3_slave_rx: got %h expected c3", s_rx); end
        n_vec++; if (cyc != 73) begin n_bad++; $display("FAIL m3_done_time: got %0d expected 73", cyc); end
        n_vec++; if (ri != 8) begin n_bad++; $display("FAIL m3_rises: got %0d expected 8", ri); end
        n_vec++; if (fa != 8) begin n_bad++; $display("FAIL m3_falls: got %0d expected 8", fa); end
        n_vec++; if (cs !== 2'b10) begin n_bad++; $display("FAIL m3_cs_seen: got %b expected 10", cs); end
        n_vec++; if (sclk0 !== 1'b1) begin n_bad++; $display("FAIL m3_end_sclk: got %b expected 1", sclk0); end
        cpol = 1'b0; cpha = 1'b0; loop0 = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_lsb16();
        int cyc, ri, fa; logic [1:0] cs; logic [15:0] mb, rd; logic gd;
        run_xfer(1, 2'd0, 16'h1234, cyc, ri, fa, cs, mb, rd, gd);
        n_vec++; if (mb[3:0] !== 4'b0100) begin n_bad++; $display("FAIL l16_first_bits: got %b expected 0100", mb[3:0]); end
        n_vec++; if (mb !== 16'h1234) begin n_bad++; $display("FAIL l16_mosi_word: got %h expected 1234", mb); end
        n_vec++; if (rd !== 16'h1234) begin n_bad++; $display("FAIL l16_data: got %h expected 1234", rd); end
        n_vec++; if (cyc != 35) begin n_bad++; $display("FAIL l16_done_time: got %0d expected 35", cyc); end
        n_vec++; if (ri != 16) begin n_bad++; $display("FAIL l16_rises: got %0d expected 16", ri); end
        n_vec++; if (cs !== 2'b01) begin n_bad++; $display("FAIL l16_cs_seen: got %b expected 01", cs); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic gd;
        loop0 = 1'b1;
        @(negedge clk);
        cs_sel0 = 2'd0; din0 = 8'h5A; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; cyc = 1; gd = 1'b0;
        while (cyc < 300) begin
            if (cyc == 20) begin start0 = 1'b1; din0 = 8'hFF; end
            if (cyc == 21) start0 = 1'b0;
            if (done0) begin gd = 1'b1; break; end
            @(posedge clk); #1; cyc++;
        end
        $display("xfer dut0 first din=5a dout=%h cycles=%0d", dout0, cyc);
        n_vec++; if (gd !== 1'b1) begin n_bad++; $display("FAIL b2b_first_done: got %b expected 1", gd); end
        n_vec++; if (cyc != 73) begin n_bad++; $display("FAIL b2b_first_time: got %0d expected 73", cyc); end
        n_vec++; if (dout0 !== 8'h5A) begin n_bad++; $display("FAIL b2b_first_data: got %h expected 5a", dout0); end
        din0 = 8'h96; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        n_vec++; if (busy0 !== 1'b1) begin n_bad++; $display("FAIL b2b_busy: got %b expected 1", busy0); end
        n_vec++; if (cs_n0 !== 2'b10) begin n_bad++; $display("FAIL b2b_cs_n: got %b expected 10", cs_n0); end
        cyc = 1; gd = 1'b0;
        while (cyc < 300) begin
            if (done0) begin gd = 1'b1; break; end
            @(posedge clk); #1; cyc++;
        end
        $display("xfer dut0 second din=96 dout=%h cycles=%0d", dout0, cyc);
        n_vec++; if (cyc != 73) begin n_bad++; $display("FAIL b2b_second_time: got %0d expected 73", cyc); end
        n_vec++; if (dout0 !== 8'h96) begin n_bad++; $display("FAIL b2b_second_data: got %h expected 96", dout0); end
    endtask

    task automatic test_reset_mid();
        int cyc, ri, fa, dones; logic [1:0] cs; logic [15:0] mb, rd; logic gd;
        loop0 = 1'b1;
        @(negedge clk);
        cs_sel0 = 2'd0; din0 = 8'h3C; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("xfer dut0 din=3c aborted by reset in half-period 5");
        n_vec++; if (cs_n0 !== 2'b11) begin n_bad++; $display("FAIL rmid_cs_n: got %b expected 11", cs_n0); end
        n_vec++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b expected 0", busy0); end
        n_vec++; if (sclk0 !== 1'b0) begin n_bad++; $display("FAIL rmid_sclk: got %b expected 0", sclk0); end
        n_vec++; if (dout0 !== 8'h00) begin n_bad++; $display("FAIL rmid_dout: got %h expected 00", dout0); end
        dones = 0;
        for (int i = 0; i < 100; i++) begin
            if (done0) dones++;
            @(posedge clk); #1;
        end
        n_vec++; if (dones != 0) begin n_bad++; $display("FAIL rmid_no_done: got %0d expected 0", dones); end
        run_xfer(0, 2'd0, 16'h00C7, cyc, ri, fa, cs, mb, rd, gd);
        n_vec++; if (rd !== 16'h00C7) begin n_bad++; $display("FAIL rmid_after_data: got %h expected 00c7", rd); end
        n_vec++; if (cyc != 73) begin n_bad++; $display("FAIL rmid_after_time: got %0d expected 73", cyc); end
    endtask

    task automatic test_bad_cs();
        int cyc, ri, fa; logic [1:0] cs; logic [15:0] mb, rd; logic gd;
        loop0 = 1'b1;
        run_xfer(0, 2'd3, 16'h0081, cyc, ri, fa, cs, mb, rd, gd);
        n_vec++; if (cs !== 2'b00) begin n_bad++; $display("FAIL badcs_cs_seen: got %b expected 00", cs); end
        n_vec++; if (ri != 8) begin n_bad++; $display("FAIL badcs_rises: got %0d expected 8", ri); end
        n_vec++; if (gd !== 1'b1) begin n_bad++; $display("FAIL badcs_done: got %b expected 1", gd); end
        n_vec++; if (cyc != 73) begin n_bad++; $display("FAIL badcs_time: got %0d expected 73", cyc); end
        n_vec++; if (rd !== 16'h0081) begin n_bad++; $display("FAIL badcs_data: got %h expected 0081", rd); end
    endtask

    initial begin
        rst = 1'b1; cpol = 1'b0; cpha = 1'b0; loop0 = 1'b1;
        start0 = 1'b0; cs_sel0 = 2'd0; din0 = 8'h00;
        start1 = 1'b0; cs_sel1 = 1'b0; din1 = 16'h0000;
        test_reset();
        test_mode0_loopback();
        test_mode3_slave();
        test_lsb16();
        test_back_to_back();
        test_reset_mid();
        test_bad_cs();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
